// File: rtl/temp_comp_pkg.sv
// Shared encodings and state type for the temperature comparator.
// The temp_comp codes are also consumed by the AC controller FSM.
package temp_comp_pkg;

    localparam logic [1:0] TC_EQUAL = 2'b00;
    localparam logic [1:0] TC_HIGH  = 2'b10;
    localparam logic [1:0] TC_LOW   = 2'b01;

    typedef enum logic [1:0] {
        ST_EQUAL = 2'b00,
        ST_HIGH  = 2'b10,
        ST_LOW   = 2'b01
    } tc_state_t;

    // Map a state to its output code; anything unexpected reads as EQUAL so 11 never leaves the block.
    function automatic logic [1:0] tc_encode(input tc_state_t st);
        logic [1:0] code;
        case (st)
            ST_HIGH:  code = TC_HIGH;
            ST_LOW:   code = TC_LOW;
            ST_EQUAL: code = TC_EQUAL;
            default:  code = TC_EQUAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/temp_comparator_if.sv
// Sample/result bus between the sensor front end and the temperature comparator.
interface temp_comparator_if #(
    parameter int W = 8
);
    logic         sample_valid;
    logic [W-1:0] sample_temp;
    logic [W-1:0] setpoint;
    logic [1:0]   temp_comp;
    logic         comp_valid;

    modport master (
        output sample_valid, sample_temp, setpoint,
        input  temp_comp, comp_valid
    );

    modport slave (
        input  sample_valid, sample_temp, setpoint,
        output temp_comp, comp_valid
    );
endinterface

// File: rtl/temp_avg4.sv
// Four-sample moving average: shift window, fill counter and registered running sum.
// Output is valid only once four samples have been accepted since reset or power-up.
module temp_avg4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         power,
    input  logic         in_valid,
    input  logic [W-1:0] in_temp,
    input  logic [W-1:0] in_setpoint,
    output logic         out_valid,
    output logic [W-1:0] out_temp,
    output logic [W-1:0] out_setpoint
);

    logic [W-1:0] win_r [4];
    logic [W+1:0] sum_r;
    logic [W+1:0] sum_s;
    logic [2:0]   fill_r;
    logic [W-1:0] setpt_r;
    logic         valid_r;

    // Running sum: new sample enters, oldest entry leaves; empty slots hold zero.
    always_comb begin
        sum_s = sum_r + (W+2)'(in_temp) - (W+2)'(win_r[3]);
    end

    // Window, sum and fill tracking; power low empties the window.
    always_ff @(posedge clk) begin
        if (!reset || !power) begin
            for (int i = 0; i < 4; i++) begin
                win_r[i] <= '0;
            end
            sum_r   <= '0;
            fill_r  <= 3'd0;
            setpt_r <= '0;
            valid_r <= 1'b0;
        end else if (in_valid) begin
            win_r[0] <= in_temp;
            win_r[1] <= win_r[0];
            win_r[2] <= win_r[1];
            win_r[3] <= win_r[2];
            sum_r    <= sum_s;
            fill_r   <= (fill_r == 3'd4) ? 3'd4 : fill_r + 3'd1;
            setpt_r  <= in_setpoint;
            valid_r  <= (fill_r >= 3'd3);
        end else begin
            valid_r  <= 1'b0;
        end
    end

    assign out_valid    = valid_r;
    assign out_temp     = W'(sum_r >> 2);
    assign out_setpoint = setpt_r;

endmodule

// File: rtl/temp_comparator.sv
// Hysteretic, persistence-filtered temperature classifier producing temp_comp.
// Define TEMP_COMP_AVG_EN to classify a 4-sample floor average instead of raw samples.
module temp_comparator
    import temp_comp_pkg::*;
#(
    parameter int W       = 8,
    parameter int HYST    = 2,
    parameter int PERSIST = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               power,
    temp_comparator_if.slave   bus
);

    localparam logic [W:0] HYST_EXT  = (W+1)'(HYST);
    localparam logic [3:0] PERSIST_C = 4'(PERSIST);

    logic         proc_s;
    logic [W-1:0] t_cmp_s;
    logic [W-1:0] s_cmp_s;

`ifdef TEMP_COMP_AVG_EN
    logic         avg_valid_s;
    logic [W-1:0] avg_temp_s;
    logic [W-1:0] avg_setpoint_s;

    temp_avg4 #(.W(W)) u_avg (
        .clk          (clk),
        .reset        (reset),
        .power        (power),
        .in_valid     (bus.sample_valid),
        .in_temp      (bus.sample_temp),
        .in_setpoint  (bus.setpoint),
        .out_valid    (avg_valid_s),
        .out_temp     (avg_temp_s),
        .out_setpoint (avg_setpoint_s)
    );

    assign proc_s  = avg_valid_s;
    assign t_cmp_s = avg_temp_s;
    assign s_cmp_s = avg_setpoint_s;
`else
    assign proc_s  = bus.sample_valid;
    assign t_cmp_s = bus.sample_temp;
    assign s_cmp_s = bus.setpoint;
`endif

    tc_state_t  state_r, state_n;
    tc_state_t  pend_r, pend_n;
    tc_state_t  cand_s;
    logic [3:0] cnt_r, cnt_n, cnt_tmp_s;
    logic       valid_n;
    logic [1:0] tc_r;
    logic       valid_r;
    logic [W:0] t_ext_s, s_ext_s;
    logic       above_s, below_s;

    // Band tests in W+1 bits so setpoint+HYST and sample+HYST cannot wrap.
    always_comb begin
        t_ext_s = {1'b0, t_cmp_s};
        s_ext_s = {1'b0, s_cmp_s};
        above_s = (t_ext_s > (s_ext_s + HYST_EXT));
        below_s = ((t_ext_s + HYST_EXT) < s_ext_s);
    end

    // Candidate class: leaving HIGH/LOW only needs to cross the setpoint, entering needs the band.
    always_comb begin
        cand_s = ST_EQUAL;
        case (state_r)
            ST_EQUAL: begin
                if (above_s)      cand_s = ST_HIGH;
                else if (below_s) cand_s = ST_LOW;
                else              cand_s = ST_EQUAL;
            end
            ST_HIGH: begin
                if (below_s)                  cand_s = ST_LOW;
                else if (t_ext_s <= s_ext_s)  cand_s = ST_EQUAL;
                else                          cand_s = ST_HIGH;
            end
            ST_LOW: begin
                if (above_s)                  cand_s = ST_HIGH;
                else if (t_ext_s >= s_ext_s)  cand_s = ST_EQUAL;
                else                          cand_s = ST_LOW;
            end
            default: cand_s = ST_EQUAL;
        endcase
    end

    // Persistence filter next-state: power low wins over any sample in flight.
    always_comb begin
        state_n   = state_r;
        pend_n    = pend_r;
        cnt_n     = cnt_r;
        cnt_tmp_s = 4'd0;
        valid_n   = 1'b0;
        if (!power) begin
            state_n = ST_EQUAL;
            cnt_n   = 4'd0;
            valid_n = 1'b0;
        end else if (proc_s) begin
            valid_n = 1'b1;
            if (cand_s == state_r) begin
                cnt_n = 4'd0;
            end else begin
                if (cand_s == pend_r) begin
                    cnt_tmp_s = cnt_r + 4'd1;
                end else begin
                    pend_n    = cand_s;
                    cnt_tmp_s = 4'd1;
                end
                if (cnt_tmp_s >= PERSIST_C) begin
                    state_n = cand_s;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n   = cnt_tmp_s;
                end
            end
        end else begin
            valid_n = 1'b0;
        end
    end

    // State, pending class, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_EQUAL;
            pend_r  <= ST_EQUAL;
            cnt_r   <= 4'd0;
            tc_r    <= TC_EQUAL;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_n;
            pend_r  <= pend_n;
            cnt_r   <= cnt_n;
            tc_r    <= tc_encode(state_n);
            valid_r <= valid_n;
        end
    end

    assign bus.temp_comp  = tc_r;
    assign bus.comp_valid = valid_r;

endmodule

// File: tb/tb_temp_comparator.sv
// Directed self-checking bench for temp_comparator (W=8, HYST=2, PERSIST=3, S=100 unless changed).
module tb_temp_comparator;
    import temp_comp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic power;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    temp_comparator_if #(.W(8)) bus ();

    temp_comparator #(.W(8), .HYST(2), .PERSIST(3)) dut (
        .clk   (clk),
        .reset (reset),
        .power (power),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then settle just after the rising edge.
    task automatic step(input logic v, input logic [7:0] t);
        bus.sample_valid = v;
        bus.sample_temp  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [7:0] t, input logic [1:0] exp_tc);
        step(1'b1, t);
        check({tag, "_tc"}, bus.temp_comp, exp_tc);
        check({tag, "_cv"}, {1'b0, bus.comp_valid}, 2'b01);
    endtask

    initial begin
        reset            = 1'b0;
        power            = 1'b1;
        bus.setpoint     = 8'd100;
        bus.sample_valid = 1'b0;
        bus.sample_temp  = 8'd0;

        // Reset held two cycles with a valid sample present
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'd110);
            check("rst_tc", bus.temp_comp, TC_EQUAL);
            check("rst_cv", {1'b0, bus.comp_valid}, 2'b00);
        end
        reset = 1'b1;
        step(1'b0, 8'd0);
        check("post_rst_tc", bus.temp_comp, TC_EQUAL);
        check("post_rst_cv", {1'b0, bus.comp_valid}, 2'b00);

`ifdef TEMP_COMP_AVG_EN
        // Windows of 100,100,104,108 average to 103; first result after the fourth sample
        begin
            logic [7:0] pat [4];
            pat[0] = 8'd100; pat[1] = 8'd100; pat[2] = 8'd104; pat[3] = 8'd108;
            for (int i = 1; i <= 12; i++) begin
                step(1'b1, pat[(i-1)%4]);
                check("avg_cv", {1'b0, bus.comp_valid}, (i >= 5) ? 2'b01 : 2'b00);
                check("avg_tc", bus.temp_comp, (i >= 7) ? TC_HIGH : TC_EQUAL);
            end
            step(1'b0, 8'd0);
            check("avg_last_cv", {1'b0, bus.comp_valid}, 2'b01);
            check("avg_last_tc", bus.temp_comp, TC_HIGH);
            step(1'b0, 8'd0);
            check("avg_idle_cv", {1'b0, bus.comp_valid}, 2'b00);
        end
`else
        // Enter HIGH
        send("high1", 8'd103, TC_EQUAL);
        send("high2", 8'd103, TC_EQUAL);
        send("high3", 8'd103, TC_HIGH);
        step(1'b0, 8'd0);
        check("idle_cv", {1'b0, bus.comp_valid}, 2'b00);
        check("idle_tc", bus.temp_comp, TC_HIGH);

        // Hysteresis out of HIGH
        for (int i = 0; i < 3; i++) send("hold101", 8'd101, TC_HIGH);
        send("eq100_1", 8'd100, TC_HIGH);
        send("eq100_2", 8'd100, TC_HIGH);
        send("eq100_3", 8'd100, TC_EQUAL);
        for (int i = 0; i < 5; i++) send("band99", 8'd99, TC_EQUAL);

        // Broken run restarts the count
        send("brk1", 8'd97, TC_EQUAL);
        send("brk2", 8'd97, TC_EQUAL);
        send("brk3", 8'd103, TC_EQUAL);
        send("brk4", 8'd97, TC_EQUAL);
        send("brk5", 8'd97, TC_EQUAL);
        send("brk6", 8'd97, TC_LOW);

        // Back to EQUAL from LOW by reaching the setpoint
        send("low_eq1", 8'd100, TC_LOW);
        send("low_eq2", 8'd100, TC_LOW);
        send("low_eq3", 8'd100, TC_EQUAL);

        // Power drop mid-persistence discards the count and the coincident sample
        send("pd1", 8'd97, TC_EQUAL);
        send("pd2", 8'd97, TC_EQUAL);
        power = 1'b0;
        step(1'b1, 8'd97);
        check("pd_off_cv", {1'b0, bus.comp_valid}, 2'b00);
        check("pd_off_tc", bus.temp_comp, TC_EQUAL);
        power = 1'b1;
        send("pd3", 8'd97, TC_EQUAL);
        send("pd4", 8'd97, TC_EQUAL);
        send("pd5", 8'd97, TC_LOW);

        // Power drop also forces LOW back to EQUAL
        power = 1'b0;
        step(1'b0, 8'd0);
        check("pd_force_tc", bus.temp_comp, TC_EQUAL);
        power = 1'b1;

        // Bottom edge: S=0
        bus.setpoint = 8'd0;
        for (int i = 0; i < 3; i++) send("s0_t0", 8'd0, TC_EQUAL);
        for (int i = 0; i < 3; i++) send("s0_t2", 8'd2, TC_EQUAL);
        send("s0_t3a", 8'd3, TC_EQUAL);
        send("s0_t3b", 8'd3, TC_EQUAL);
        send("s0_t3c", 8'd3, TC_HIGH);

        // Top edge: S=255
        power = 1'b0;
        step(1'b0, 8'd0);
        power = 1'b1;
        bus.setpoint = 8'd255;
        for (int i = 0; i < 3; i++) send("s255_t255", 8'd255, TC_EQUAL);
        for (int i = 0; i < 3; i++) send("s255_t253", 8'd253, TC_EQUAL);
        send("s255_t252a", 8'd252, TC_EQUAL);
        send("s255_t252b", 8'd252, TC_EQUAL);
        send("s255_t252c", 8'd252, TC_LOW);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
